regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter.sv | 83 ++++++++
 tb/tb_regfile_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester round-robin front end for a single-write/single-read register file
//   clk, rst          : clock, synchronous active-high reset
//   a_* / b_*         : requester ports (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   init_busy         : high while registers are being cleared after reset
//   rf_wr_*           : register file write port
//   rf_rd_addr/data   : register file combinational read port
module regfile_arbiter #(
    parameter int NUM_REGS = 16,
    parameter int SIZE     = 32,
    parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_req,
    input  logic            a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [SIZE-1:0] a_wdata,
    output logic            a_gnt,
    output logic            a_rvalid,
    output logic [SIZE-1:0] a_rdata,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [AW-1:0]   b_addr,
    input  logic [SIZE-1:0] b_wdata,
    output logic            b_gnt,
    output logic            b_rvalid,
    output logic [SIZE-1:0] b_rdata,
    output logic            init_busy,
    output logic            rf_wr_en,
    output logic [AW-1:0]   rf_wr_addr,
    output logic [SIZE-1:0] rf_wr_data,
    output logic [AW-1:0]   rf_rd_addr,
    input  logic [SIZE-1:0] rf_rd_data
);
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] ARB  = 1'b1;
    logic [0:0]    state;
    logic [AW-1:0] cnt;
    logic          prio;
    logic          in_init, in_arb, a_rd, b_rd, a_wr, b_wr;
    // rst masks every port-facing strobe in the same cycle it is high
    always_comb begin
        in_init    = !rst && state == INIT;
        in_arb     = !rst && state == ARB;
        a_gnt      = in_arb && a_req && (!b_req || !prio);
        b_gnt      = in_arb && b_req && (!a_req || prio);
        a_wr       = a_gnt && a_we;
        b_wr       = b_gnt && b_we;
        a_rd       = a_gnt && !a_we;
        b_rd       = b_gnt && !b_we;
        rf_wr_en   = in_init || a_wr || b_wr;
        rf_wr_addr = in_init ? cnt : a_wr ? a_addr : b_wr ? b_addr : '0;
        rf_wr_data = a_wr ? a_wdata : b_wr ? b_wdata : '0;
        rf_rd_addr = a_rd ? a_addr : b_rd ? b_addr : '0;
    end
    assign init_busy = state == INIT;
    // prio=1 means B wins the next tie; it flips only when someone is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            cnt      <= '0;
            prio     <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_rd;
            b_rvalid <= b_rd;
            if (a_rd) a_rdata <= rf_rd_data;
            if (b_rd) b_rdata <= rf_rd_data;
            if (a_gnt) prio <= 1'b1;
            else if (b_gnt) prio <= 1'b0;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == AW'(NUM_REGS - 1)) begin
                    state <= ARB;
                    cnt   <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed scoreboard bench for regfile_arbiter with an attached register file
module tb_regfile_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, init_busy, rf_wr_en;
    logic [31:0] a_rdata, b_rdata, rf_wr_data, rf_rd_data;
    logic [3:0]  rf_wr_addr, rf_rd_addr;
    logic [31:0] mem [16];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    regfile_arbiter #(.NUM_REGS(16), .SIZE(32)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_busy(init_busy), .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
    );

    assign rf_rd_data = mem[rf_rd_addr];
    always @(posedge clk) if (rf_wr_en) mem[rf_wr_addr] <= rf_wr_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_seq;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("init_busy", 32'(init_busy), 32'd1);
            chk("init_wen", 32'(rf_wr_en), 32'd1);
            chk("init_waddr", 32'(rf_wr_addr), 32'(i));
            chk("init_wdata", rf_wr_data, 32'd0);
            chk("init_agnt", 32'(a_gnt), 32'd0);
            tick;
        end
    endtask

    // read scoreboard: expectations pushed at grant, popped when rvalid shows up
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            if (qa.size() == 0) chk("a_rvalid_unexpected", 32'd1, 32'd0);
            else chk("a_rdata", a_rdata, qa.pop_front());
        end
        if (b_rvalid === 1'b1) begin
            if (qb.size() == 0) chk("b_rvalid_unexpected", 32'd1, 32'd0);
            else chk("b_rdata", b_rdata, qb.pop_front());
        end
    end

    initial begin
        rst = 1'b1; a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 32'h7;
        b_req = 1'b0; b_we = 1'b0; b_addr = 4'd0; b_wdata = 32'h0;
        tick;
        chk("rst_agnt", 32'(a_gnt), 32'd0);
        chk("rst_wen", 32'(rf_wr_en), 32'd0);
        chk("rst_raddr", 32'(rf_rd_addr), 32'd0);
        chk("rst_busy", 32'(init_busy), 32'd1);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        rst = 1'b0; a_we = 1'b0; a_addr = 4'd15;
        init_seq;
        #1;
        chk("arb_busy", 32'(init_busy), 32'd0);
        chk("rd15_gnt", 32'(a_gnt), 32'd1);
        chk("rd15_raddr", 32'(rf_rd_addr), 32'd15);
        chk("rd15_wen", 32'(rf_wr_en), 32'd0);
        qa.push_back(32'd0);
        tick;
        a_we = 1'b1; a_addr = 4'd1; a_wdata = 32'hFFFF_FFFF;
        #1;
        chk("wr1_gnt", 32'(a_gnt), 32'd1);
        chk("wr1_wen", 32'(rf_wr_en), 32'd1);
        chk("wr1_waddr", 32'(rf_wr_addr), 32'd1);
        chk("wr1_wdata", rf_wr_data, 32'hFFFF_FFFF);
        tick;
        a_we = 1'b0;
        #1;
        chk("rd1_gnt", 32'(a_gnt), 32'd1);
        chk("rd1_raddr", 32'(rf_rd_addr), 32'd1);
        qa.push_back(32'hFFFF_FFFF);
        tick;
        a_req = 1'b0;
        #1;
        chk("rd1_rvalid", 32'(a_rvalid), 32'd1);
        chk("idle_agnt", 32'(a_gnt), 32'd0);
        chk("idle_wen", 32'(rf_wr_en), 32'd0);
        chk("idle_waddr", 32'(rf_wr_addr), 32'd0);
        tick;
        chk("rvalid_pulse", 32'(a_rvalid), 32'd0);
        chk("a_rdata_hold", a_rdata, 32'hFFFF_FFFF);
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd15; a_wdata = 32'h5A;
        #1;
        chk("wr15_gnt", 32'(a_gnt), 32'd1);
        tick;
        a_req = 1'b0; b_req = 1'b1; b_we = 1'b0; b_addr = 4'd15;
        #1;
        chk("b_rd15_gnt", 32'(b_gnt), 32'd1);
        chk("b_rd15_raddr", 32'(rf_rd_addr), 32'd15);
        qb.push_back(32'h5A);
        tick;
        b_req = 1'b0;
        #1;
        chk("b_rvalid", 32'(b_rvalid), 32'd1);
        chk("a_rdata_kept", a_rdata, 32'hFFFF_FFFF);
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 32'hAA;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_agnt", 32'(a_gnt), 32'(i % 2 == 0));
            chk("rr_bgnt", 32'(b_gnt), 32'(i % 2 == 1));
            if (i % 2 == 1) qb.push_back(32'hAA);
            tick;
        end
        a_req = 1'b0; b_req = 1'b0;
        tick;
        b_req = 1'b1; b_addr = 4'd2;
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 32'h77;
        rst = 1'b1;
        #1;
        chk("rst_arb_bgnt", 32'(b_gnt), 32'd0);
        chk("rst_arb_agnt", 32'(a_gnt), 32'd0);
        chk("rst_arb_wen", 32'(rf_wr_en), 32'd0);
        chk("rst_arb_raddr", 32'(rf_rd_addr), 32'd0);
        tick;
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
        chk("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("rst_b_rdata", b_rdata, 32'd0);
        init_seq;
        for (int i = 0; i < 16; i++) chk("cleared", mem[i], 32'd0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd2;
        #1;
        chk("post_agnt", 32'(a_gnt), 32'd1);
        chk("post_bgnt", 32'(b_gnt), 32'd0);
        qa.push_back(32'd0);
        tick;
        a_req = 1'b0;
        #1;
        chk("post_bgnt2", 32'(b_gnt), 32'd1);
        qb.push_back(32'd0);
        tick;
        b_req = 1'b0; a_req = 1'b1; a_addr = 4'd3;
        #1;
        chk("rd3_gnt", 32'(a_gnt), 32'd1);
        qa.push_back(32'd0);
        tick;
        a_req = 1'b0;
        tick;
        tick;
        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
